// File: rtl/sw_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_button_debounce
// Purpose  : Synchronise, debounce and edge-detect board switches/buttons,
//            with sticky W1C button event flags and a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module sw_button_debounce #(
    parameter int NUM_SW          = 8,
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic [NUM_SW-1:0]  sw_in,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_SW-1:0]  sw_stable,
    output logic [NUM_BTN-1:0] btn_stable,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    input  logic [NUM_BTN-1:0] evt_clr,
    input  logic [NUM_BTN-1:0] irq_en,
    output logic [NUM_BTN-1:0] btn_evt_pending,
    output logic               irq
);

    localparam int c_num_lines = NUM_SW + NUM_BTN;
    localparam int c_top       = c_num_lines - 1;
    localparam int c_cnt_w     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // Switches occupy the low bits of every line vector, buttons the high bits.
    logic [c_top:0]       s1_q, s1_d;
    logic [c_top:0]       s2_q, s2_d;
    logic [c_top:0]       stable_q, stable_d;
    logic [c_top:0]       line_upd;
    logic [NUM_BTN-1:0]   press_q, press_d;
    logic [NUM_BTN-1:0]   release_q, release_d;
    logic [NUM_BTN-1:0]   pending_q, pending_d;
    logic                 irq_q, irq_d;

    generate
        for (genvar i = 0; i < c_num_lines; i++) begin : g_line
            logic [c_cnt_w-1:0] cnt_q, cnt_d;
            logic               upd;

            always_comb begin
                cnt_d = '0;
                upd   = 1'b0;
                if (s2_q[i] != stable_q[i]) begin
                    if (cnt_q == c_cnt_last) begin
                        upd = 1'b1;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
            end

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign line_upd[i] = upd;
        end
    endgenerate

    always_comb begin
        s1_d      = {btn_in, sw_in};
        s2_d      = s1_q;
        stable_d  = stable_q ^ line_upd;
        // Pulses are registered alongside stable so both change on the same edge.
        press_d   = line_upd[c_top:NUM_SW] &  s2_q[c_top:NUM_SW];
        release_d = line_upd[c_top:NUM_SW] & ~s2_q[c_top:NUM_SW];
        pending_d = (pending_q & ~evt_clr) | press_q;
        irq_d     = |(pending_q & irq_en);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign sw_stable       = stable_q[NUM_SW-1:0];
    assign btn_stable      = stable_q[c_top:NUM_SW];
    assign btn_press       = press_q;
    assign btn_release     = release_q;
    assign btn_evt_pending = pending_q;
    assign irq             = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_button_debounce
// Purpose  : Self-checking bench for sw_button_debounce (DEBOUNCE_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_button_debounce;

    localparam int D  = 4;
    localparam int NL = 12;

    logic       ACLK;
    logic       ARESETN;
    logic [7:0] sw_in;
    logic [3:0] btn_in;
    logic [7:0] sw_stable;
    logic [3:0] btn_stable, btn_press, btn_release;
    logic [3:0] evt_clr, irq_en, btn_evt_pending;
    logic       irq;

    int total = 0;
    int bad   = 0;

    sw_button_debounce #(
        .NUM_SW          (8),
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .sw_in           (sw_in),
        .btn_in          (btn_in),
        .sw_stable       (sw_stable),
        .btn_stable      (btn_stable),
        .btn_press       (btn_press),
        .btn_release     (btn_release),
        .evt_clr         (evt_clr),
        .irq_en          (irq_en),
        .btn_evt_pending (btn_evt_pending),
        .irq             (irq)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reference model: a line's stable value flips once the last D synchronised
    // samples all disagree with it; samples reach the checker two edges late.
    logic [NL-1:0] win [0:D];
    logic [NL-1:0] m_stable, m_flip;
    logic [3:0]    m_press, m_release, m_pend;
    logic          m_irq;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int j = 0; j <= D; j++) win[j] = '0;
            m_stable  = '0;
            m_press   = '0;
            m_release = '0;
            m_pend    = '0;
            m_irq     = 1'b0;
        end else begin
            m_flip = '1;
            for (int j = 1; j <= D; j++) m_flip = m_flip & (win[j] ^ m_stable);
            m_irq     = |(m_pend & irq_en);
            m_pend    = (m_pend & ~evt_clr) | m_press;
            m_stable  = m_stable ^ m_flip;
            m_press   = m_flip[11:8] &  m_stable[11:8];
            m_release = m_flip[11:8] & ~m_stable[11:8];
            for (int j = D; j > 0; j--) win[j] = win[j-1];
            win[0] = {btn_in, sw_in};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    typedef struct {
        logic [3:0] btn;
        logic [3:0] stab;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] pend;
        logic       irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] b, input logic [3:0] s, input logic [3:0] p,
                                input logic [3:0] r, input logic [3:0] pe, input logic q);
        vec_t v;
        v.btn = b; v.stab = s; v.press = p; v.rel = r; v.pend = pe; v.irq = q;
        vecs.push_back(v);
    endfunction

    logic [NL-1:0] rnd_raw;

    initial begin
        sw_in   = '0;
        btn_in  = '0;
        evt_clr = '0;
        irq_en  = 4'hF;
        ARESETN = 1'b1;
        #1 ARESETN = 1'b0;
        #2;
        chk("reset_outputs", 32'({sw_stable, btn_stable, btn_press, btn_release, btn_evt_pending, irq}), 32'd0);
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;

        // Clean press of button 0, then bounce on button 1 that must be rejected.
        for (int i = 0; i < 5; i++) add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        for (int i = 0; i < 7; i++) add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);

        foreach (vecs[i]) begin
            btn_in = vecs[i].btn;
            tick();
            chk($sformatf("vec%0d_stable", i),  32'(btn_stable),      32'(vecs[i].stab));
            chk($sformatf("vec%0d_press", i),   32'(btn_press),       32'(vecs[i].press));
            chk($sformatf("vec%0d_release", i), 32'(btn_release),     32'(vecs[i].rel));
            chk($sformatf("vec%0d_pending", i), 32'(btn_evt_pending), 32'(vecs[i].pend));
            chk($sformatf("vec%0d_irq", i),     32'(irq),             32'(vecs[i].irq));
        end

        // Clear button 0's flag.
        evt_clr = 4'b0001;
        tick();
        evt_clr = 4'b0000;
        chk("clr_pending", 32'(btn_evt_pending), 32'd0);
        chk("clr_irq_lag", 32'(irq), 32'd1);
        tick();
        chk("clr_irq_drop", 32'(irq), 32'd0);

        // Set and clear coincide on button 2 with interrupts masked.
        irq_en = 4'b0000;
        btn_in = 4'b0101;
        repeat (5) tick();
        chk("sim_press_early", 32'(btn_press), 32'd0);
        tick();
        chk("sim_press", 32'(btn_press), 32'b0100);
        evt_clr = 4'b0100;
        tick();
        evt_clr = 4'b0000;
        chk("sim_pending_kept", 32'(btn_evt_pending), 32'b0100);
        chk("sim_irq_masked", 32'(irq), 32'd0);
        tick();
        chk("sim_irq_masked2", 32'(irq), 32'd0);
        irq_en = 4'b0100;
        tick();
        chk("sim_irq_unmasked", 32'(irq), 32'd1);

        // Switch levels, then release of button 0.
        sw_in = 8'hA5;
        repeat (5) tick();
        chk("sw_early", 32'(sw_stable), 32'd0);
        tick();
        chk("sw_stable", 32'(sw_stable), 32'hA5);
        btn_in = 4'b0100;
        repeat (5) tick();
        chk("rel_early", 32'(btn_release), 32'd0);
        tick();
        chk("rel_pulse", 32'(btn_release), 32'b0001);
        chk("rel_stable", 32'(btn_stable), 32'b0100);
        chk("rel_no_press", 32'(btn_press), 32'd0);
        tick();
        chk("rel_pulse_end", 32'(btn_release), 32'd0);
        chk("rel_pending", 32'(btn_evt_pending), 32'b0100);

        // Reset while button 3 is mid-count; held inputs re-qualify afterwards.
        btn_in = 4'b1100;
        repeat (4) tick();
        ARESETN = 1'b0;
        #2;
        chk("rst_mid_outputs", 32'({sw_stable, btn_stable, btn_press, btn_release, btn_evt_pending, irq}), 32'd0);
        #5 ARESETN = 1'b1;
        repeat (5) tick();
        chk("rst_btn_early", 32'(btn_stable), 32'd0);
        tick();
        chk("rst_btn_stable", 32'(btn_stable), 32'b1100);
        chk("rst_sw_stable", 32'(sw_stable), 32'hA5);
        chk("rst_press", 32'(btn_press), 32'b1100);
        tick();
        chk("rst_pending", 32'(btn_evt_pending), 32'b1100);
        chk("rst_irq_lag", 32'(irq), 32'd0);
        tick();
        chk("rst_irq", 32'(irq), 32'd1);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 2000; c++) begin
            rnd_raw = {btn_in, sw_in};
            if ($urandom_range(0, 2) == 0) rnd_raw[$urandom_range(0, NL-1)] ^= 1'b1;
            sw_in   = rnd_raw[7:0];
            btn_in  = rnd_raw[11:8];
            evt_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 31) == 0) irq_en = 4'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                ARESETN = 1'b0;
                #2 ARESETN = 1'b1;
            end
            tick();
            chk("rnd_sw_stable",  32'(sw_stable),       32'(m_stable[7:0]));
            chk("rnd_btn_stable", 32'(btn_stable),      32'(m_stable[11:8]));
            chk("rnd_press",      32'(btn_press),       32'(m_press));
            chk("rnd_release",    32'(btn_release),     32'(m_release));
            chk("rnd_pending",    32'(btn_evt_pending), 32'(m_pend));
            chk("rnd_irq",        32'(irq),             32'(m_irq));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_button_debounce.md
# sw_button_debounce

Input conditioning stage directly upstream of the switch/button AXI4-Lite register interface. Synchronises raw board switches and push-buttons into ACLK, debounces each line with a per-input counter, and generates press/release pulses. Maintains sticky per-button event flags with write-1-to-clear and a level interrupt. All outputs feed the register file, which exposes them on its AXI4-Lite slave port.

## Interface
- NUM_SW, 8, number of slide-switch inputs (1..32)
- NUM_BTN, 4, number of push-button inputs (1..32)
- DEBOUNCE_CYCLES, 1000000, consecutive ACLK cycles a synchronised input must differ from its stable value before the stable value changes (>=1; 10 ms at 100 MHz)
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  reset; asynchronous assert, active-low; the only reset
- sw_in  in  NUM_SW  raw asynchronous switch levels
- btn_in  in  NUM_BTN  raw asynchronous button levels, 1 = pressed
- sw_stable  out  NUM_SW  debounced switch levels
- btn_stable  out  NUM_BTN  debounced button levels
- btn_press  out  NUM_BTN  one-cycle pulse per debounced 0->1 transition
- btn_release  out  NUM_BTN  one-cycle pulse per debounced 1->0 transition
- evt_clr  in  NUM_BTN  write-1-to-clear strobes for btn_evt_pending, one cycle wide
- irq_en  in  NUM_BTN  per-button interrupt enable
- btn_evt_pending  out  NUM_BTN  sticky flag, set by btn_press
- irq  out  1  registered OR of (btn_evt_pending & irq_en)

## Operation
- Synchroniser: two flops per input (s1, s2), reset to 0. s2 is the only version of an input used downstream.
- Debounce, identical for every switch and button line, one counter per line, width $clog2(DEBOUNCE_CYCLES+1):
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles (measured at s2) restarts the count; stable never changes.
- Edge pulses, registered, buttons only:
  - btn_press[i] is high for exactly the one cycle in which btn_stable[i] first reads 1.
  - btn_release[i] is high for exactly the one cycle in which btn_stable[i] first reads 0.
- Pending flags, per button:
  - next = (pending & ~evt_clr) | btn_press.
  - A set that coincides with a clear wins, so no event is lost.
  - evt_clr on an idle flag has no effect.
- irq:
  - irq <= |(btn_evt_pending & irq_en).
  - Deasserting irq_en masks irq without clearing pending.
- Inputs held high through reset are real events:
  - stable rises DEBOUNCE_CYCLES+1 cycles after the first ACLK edge following reset release.
  - btn_press and pending fire normally.
- Switches have no pulses or pending logic.

## Timing
- Reset (ARESETN low), applied asynchronously:
  - s1, s2, cnt, sw_stable, btn_stable, btn_press, btn_release, btn_evt_pending and irq all go to 0 immediately.
  - Reset mid-count discards the count; reset during a pulse truncates it.
- Latency:
  - Raw level change first sampled by s1 at edge k.
  - s2 changes at edge k+1.
  - stable, and btn_press/btn_release, update at edge k+DEBOUNCE_CYCLES+1.
  - btn_evt_pending sets at edge k+DEBOUNCE_CYCLES+2.
  - irq asserts at edge k+DEBOUNCE_CYCLES+3.
- Clear path:
  - evt_clr high in the cycle before edge m clears pending at edge m.
  - irq drops at edge m+1, unless another enabled flag is set.
- Pulses are exactly one cycle wide. There is no back-to-back press on the same line closer than DEBOUNCE_CYCLES+1 cycles apart.
- evt_clr and irq_en are synchronous to ACLK (driven by the register file); no synchronisation is applied to them.

## Test plan
- DEBOUNCE_CYCLES=4, clean press:
  - Stimulus: btn_in[0] rises before edge k and is held.
  - Required: btn_stable[0] and btn_press[0] rise at edge k+5; btn_press[0] is low at edge k+6; btn_evt_pending[0] at k+6; irq (irq_en=1) at k+7.
- Bounce rejection:
  - Stimulus: btn_in[1] toggles high 3 cycles, low 1 cycle, high 3 cycles, then low.
  - Required: btn_stable[1] stays 0; no btn_press; no pending.
- Clear:
  - Stimulus: pending[0]=1, pulse evt_clr[0] one cycle.
  - Required: pending[0] is 0 next edge; irq 0 one edge later.
- Simultaneous set and clear:
  - Stimulus: evt_clr[2] pulsed in the same cycle as btn_press[2]; irq_en=0.
  - Required: pending[2] remains 1; irq stays 0. Then setting irq_en[2]=1 gives irq=1 one edge later.
- Switches and release:
  - Stimulus: sw_in=8'hA5 held 6+ cycles, then btn_in[0] falls.
  - Required: sw_stable=8'hA5 after 5 edges; btn_release[0] one-cycle pulse; pending unchanged.
- Reset mid-count:
  - Stimulus: ARESETN low for one cycle while cnt=2.
  - Required: all outputs 0 during reset, without a clock edge. Input still held afterwards gives stable after a full DEBOUNCE_CYCLES+1 cycles from the first post-reset edge.
